phase_to_sine: RTL and testbench

PHASE_TO_SINE -- requirements
Module: phase_to_sine

---
 rtl/phase_to_sine.sv | 99 +++++++++
 tb/tb_phase_to_sine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_to_sine.sv
// Phase-to-sine converter: a three-stage pipeline that folds the phase into one quadrant,
// looks up a quarter-wave ROM built at elaboration, and restores the sign.
module phase_to_sine #(
  parameter int PHASE_WIDTH = 8,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [PHASE_WIDTH-1:0] phase,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  sine
);

  localparam int  QN = 1 << (PHASE_WIDTH - 2);
  localparam int  FW = PHASE_WIDTH - 1;
  localparam real PI = 3.14159265358979323846;

  typedef logic [QN:0][DATA_WIDTH-1:0] rom_t;

  function automatic logic signed [DATA_WIDTH-1:0] round_haz(input real x);
    integer v;
    if (x >= 0.0) v = $rtoi(x + 0.5);
    else          v = -$rtoi(0.5 - x);
    return DATA_WIDTH'(v);
  endfunction

  function automatic rom_t build_rom();
    rom_t r;
    real  scale;
    scale = real'(longint'(1) << (DATA_WIDTH - 2));
    for (int k = 0; k <= QN; k++) begin
      r[k] = round_haz($sin(PI * real'(k) / real'(2 * QN)) * scale);
    end
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  logic                         adv;
  logic [PHASE_WIDTH-3:0]       low;
  logic                         vld_p1_q, vld_p1_d;
  logic                         vld_p2_q, vld_p2_d;
  logic                         vld_p3_q, vld_p3_d;
  logic                         neg_p1_q, neg_p1_d;
  logic                         neg_p2_q, neg_p2_d;
  logic [FW-1:0]                fold_p1_q, fold_p1_d;
  logic signed [DATA_WIDTH-1:0] qw_p2_q, qw_p2_d;
  logic signed [DATA_WIDTH-1:0] sine_p3_q, sine_p3_d;

  always_comb begin
    adv      = !vld_p3_q | out_ready;
    low      = phase[PHASE_WIDTH-3:0];
    vld_p1_d = adv ? in_valid : vld_p1_q;
    vld_p2_d = adv ? vld_p1_q : vld_p2_q;
    vld_p3_d = adv ? vld_p2_q : vld_p3_q;

    // Stage 1: odd quadrants mirror the index so one quarter wave covers all four.
    neg_p1_d  = phase[PHASE_WIDTH-1];
    fold_p1_d = phase[PHASE_WIDTH-2] ? (FW'(QN) - FW'(low)) : FW'(low);

    // Stage 2: quarter-wave lookup
    neg_p2_d = neg_p1_q;
    qw_p2_d  = ROM[fold_p1_q];

    // Stage 3: lower half-wave is the negated upper half; |Q| <= 2**(DW-2) cannot overflow.
    sine_p3_d = neg_p2_q ? -qw_p2_q : qw_p2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      neg_p1_q  <= neg_p1_d;
      fold_p1_q <= fold_p1_d;
      neg_p2_q  <= neg_p2_d;
      qw_p2_q   <= qw_p2_d;
      sine_p3_q <= sine_p3_d;
    end
  end

  // Gating on the valid bit keeps sine at zero through reset without resetting data flops.
  assign in_ready  = adv;
  assign out_valid = vld_p3_q;
  assign sine      = vld_p3_q ? sine_p3_q : '0;

endmodule

// File: tb/tb_phase_to_sine.sv
// Scoreboard bench for phase_to_sine (PHASE_WIDTH=8, DATA_WIDTH=32): directed vectors,
// full sweep, backpressured counter stream, mid-stream reset and bubble spacing.
module tb_phase_to_sine;

  localparam real PI = 3.14159265358979323846;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  phase;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sine;

  phase_to_sine #(.PHASE_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .phase(phase), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .sine(sine)
  );

  typedef struct {
    logic [31:0] val;
    int          xfer;
    logic [7:0]  ph;
  } item_t;

  item_t       sb[$];
  int          tests = 0;
  int          fails = 0;
  int          pops = 0;
  int          edge_cnt = 0;
  logic        rnd_mode = 1'b0;
  logic        lat_mode = 1'b1;
  logic        held = 1'b0;
  logic [31:0] held_val = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input int p);
    real x;
    int  v;
    x = $sin(2.0 * PI * real'(p) / 256.0) * 1073741824.0;
    if (x >= 0.0) v = $rtoi(x + 0.5);
    else          v = -$rtoi(0.5 - x);
    return v;
  endfunction

  // Monitor: consumes outputs, compares against the scoreboard, checks stall stability.
  initial begin
    item_t it;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", {31'b0, out_valid}, 32'd1);
          chk("hold_sine", sine, held_val);
          held = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %h expected no output", sine);
          end else begin
            it = sb.pop_front();
            chk($sformatf("sine_ph%0d", it.ph), sine, it.val);
            if (lat_mode) chk($sformatf("latency_ph%0d", it.ph), edge_cnt, it.xfer + 2);
            pops++;
          end
        end else if (out_valid) begin
          held     = 1'b1;
          held_val = sine;
        end
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic [31:0] e);
    int    w;
    item_t it;
    w        = 0;
    in_valid = 1'b1;
    phase    = p;
    #1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      it.val  = e;
      it.xfer = edge_cnt + 1;
      it.ph   = p;
      sb.push_back(it);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cnt;
    int         p0;
    reset    = 1'b1;
    in_valid = 1'b0;
    phase    = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sine", sine, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Quadrant boundaries and octant points
    send(8'd0,   32'h00000000);
    send(8'd64,  32'h40000000);
    send(8'd128, 32'h00000000);
    send(8'd192, 32'hC0000000);
    send(8'd32,  32'h2D413CCD);
    send(8'd224, 32'hD2BEC333);
    drain();

    // Bubbles stay as gaps in the output
    send(8'd32, 32'h2D413CCD);
    idle();
    send(8'd224, 32'hD2BEC333);
    idle();
    drain();

    // Full back-to-back sweep
    p0 = pops;
    for (int p = 0; p < 256; p++) send(8'(p), model(p));
    drain();
    chk("sweep_count", pops - p0, 32'd256);

    // Counter stream with random backpressure and wrap
    lat_mode = 1'b0;
    rnd_mode = 1'b1;
    cnt      = 8'd250;
    for (int inc = 1; inc <= 6; inc++) begin
      for (int i = 0; i < 50; i++) begin
        send(cnt, model(int'(cnt)));
        cnt = cnt + 8'(inc);
        if ($urandom_range(0, 3) == 0) idle();
      end
    end
    drain();
    rnd_mode = 1'b0;
    lat_mode = 1'b1;
    repeat (2) @(negedge clk);

    // Reset with three samples in flight
    send(8'd16, model(16));
    send(8'd96, model(96));
    send(8'd160, model(160));
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_sine", sine, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    phase    = 8'd200;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    send(8'd64, 32'h40000000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
